neuron_layer_scheduler: RTL and testbench

//  Time-multiplexes one shared multiply-accumulate/saturate neuron datapath over a layer of N_NEURONS neurons.
//  On start: latches the layer input vector, then for each neuron streams its weight row from an external sync-read weight memory.

---
 rtl/neuron_pkg.sv | 30 +++
 rtl/neuron_saturate.sv | 39 +++
 rtl/neuron_layer_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_neuron_layer_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constant helpers for the neuron layer scheduler.
// Honours NEURON_SCHED_BIAS_EN: when defined each weight row carries a trailing bias word.
package neuron_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC  = 3'd1,
    SAT  = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } sched_state_e;

  function automatic int sum_width(input int int_width, input int overflow_width);
    return 2 * int_width + overflow_width + 1;
  endfunction

  function automatic int row_len(input int n_in);
`ifdef NEURON_SCHED_BIAS_EN
    return n_in + 1;
`else
    return n_in;
`endif
  endfunction

  // Width of an index into n items, never narrower than one bit.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_saturate.sv
// Clamps a signed fixed-point accumulator to an unsigned INT_WIDTH activation.
// Negative sums clamp to 0, sums at or above 1.0 clamp to all-ones.
module neuron_saturate
  import neuron_pkg::*;
#(
  parameter int INT_WIDTH      = 4,
  parameter int OVERFLOW_WIDTH = 2
) (
  input  logic signed [sum_width(INT_WIDTH, OVERFLOW_WIDTH)-1:0] acc,
  output logic        [INT_WIDTH-1:0]                            sat
);

  localparam int SUM_W = sum_width(INT_WIDTH, OVERFLOW_WIDTH);

  logic ovf_s;
  logic unused_frac_s;

  if (OVERFLOW_WIDTH > 0) begin : g_ovf
    assign ovf_s = |acc[SUM_W-2 -: OVERFLOW_WIDTH];
  end else begin : g_no_ovf
    assign ovf_s = 1'b0;
  end

  // Fractional bits below the output LSB are truncated.
  assign unused_frac_s = ^acc[INT_WIDTH-1:0];

  // Clamp selection.
  always_comb begin
    sat = {INT_WIDTH{1'b0}};
    if (acc[SUM_W-1]) begin
      sat = {INT_WIDTH{1'b0}};
    end else if (ovf_s) begin
      sat = {INT_WIDTH{1'b1}};
    end else begin
      sat = acc[2*INT_WIDTH-1:INT_WIDTH];
    end
  end

endmodule

// File: rtl/neuron_layer_scheduler.sv
// Time-multiplexes one MAC/saturate datapath over a layer of neurons, streaming weights from a sync-read memory.
// Optional bias word per row when NEURON_SCHED_BIAS_EN is defined.
module neuron_layer_scheduler
  import neuron_pkg::*;
#(
  parameter int INT_WIDTH      = 4,
  parameter int N_IN           = 2,
  parameter int N_NEURONS      = 4,
  parameter int OVERFLOW_WIDTH = 2,
  parameter int WEIGHT_WIDTH   = INT_WIDTH + OVERFLOW_WIDTH + 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic        [N_IN*INT_WIDTH-1:0]                 in_vec,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             w_rd_en,
  output logic        [safe_clog2(N_NEURONS*row_len(N_IN))-1:0] w_addr,
  input  logic signed [WEIGHT_WIDTH-1:0]                   w_data,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic        [safe_clog2(N_NEURONS)-1:0]          out_id,
  output logic        [INT_WIDTH-1:0]                      out_data
);

  localparam int ROW_LEN = row_len(N_IN);
  localparam int SUM_W   = sum_width(INT_WIDTH, OVERFLOW_WIDTH);
  localparam int AW      = safe_clog2(N_NEURONS * ROW_LEN);
  localparam int IDW     = safe_clog2(N_NEURONS);
  localparam int CW      = safe_clog2(ROW_LEN + 2);

  localparam logic [CW-1:0]  ROW_LAST = CW'(ROW_LEN);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N_NEURONS - 1);
  localparam logic [IDW-1:0] ID_ONE   = IDW'(1);

  if (OVERFLOW_WIDTH < $clog2(ROW_LEN)) begin : g_ovf_check
    $error("OVERFLOW_WIDTH must be at least clog2(ROW_LEN)");
  end

  sched_state_e             state_r, state_s;
  logic [CW-1:0]            cnt_r, cnt_s, k_s;
  logic [IDW-1:0]           neuron_r, neuron_s;
  logic [INT_WIDTH-1:0]     in_r [N_IN];
  logic signed [SUM_W-1:0]  acc_r, acc_s, a_s, b_s, prod_s, term_s;
  logic [INT_WIDTH-1:0]     in_sel_s, sat_s;
  logic                     latch_s, load_out_s;
  logic                     busy_r, done_r, rd_en_r, valid_r;
  logic                     busy_s, done_s, rd_en_s, valid_s;
  logic [AW-1:0]            addr_r, addr_s;
  logic [IDW-1:0]           id_r, id_s;
  logic [INT_WIDTH-1:0]     data_r, data_s;

  // Product term for the weight word that arrived this cycle (row word cnt_r-1).
  always_comb begin
    k_s      = cnt_r - CNT_ONE;
    in_sel_s = {INT_WIDTH{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      in_sel_s = (k_s == CW'(i)) ? in_r[i] : in_sel_s;
    end
    a_s    = $signed({{(SUM_W-INT_WIDTH){1'b0}}, in_sel_s});
    b_s    = {{(SUM_W-WEIGHT_WIDTH){w_data[WEIGHT_WIDTH-1]}}, w_data};
    prod_s = a_s * b_s;
`ifdef NEURON_SCHED_BIAS_EN
    term_s = (k_s == CW'(N_IN)) ? (b_s <<< INT_WIDTH) : prod_s;
`else
    term_s = prod_s;
`endif
  end

  neuron_saturate #(
    .INT_WIDTH      (INT_WIDTH),
    .OVERFLOW_WIDTH (OVERFLOW_WIDTH)
  ) u_sat (
    .acc (acc_r),
    .sat (sat_s)
  );

  // Next-state, counters and accumulator.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    neuron_s   = neuron_r;
    acc_s      = acc_r;
    latch_s    = 1'b0;
    load_out_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = MAC;
          cnt_s    = {CW{1'b0}};
          neuron_s = {IDW{1'b0}};
          acc_s    = {SUM_W{1'b0}};
          latch_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      MAC: begin
        if (cnt_r != {CW{1'b0}}) begin
          acc_s = acc_r + term_s;
        end else begin
          acc_s = acc_r;
        end
        if (cnt_r == ROW_LAST) begin
          state_s = SAT;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      SAT: begin
        state_s    = EMIT;
        load_out_s = 1'b1;
      end
      EMIT: begin
        if (out_ready && (neuron_r == ID_LAST)) begin
          state_s  = DONE;
          neuron_s = {IDW{1'b0}};
        end else if (out_ready) begin
          state_s  = MAC;
          neuron_s = neuron_r + ID_ONE;
          cnt_s    = {CW{1'b0}};
          acc_s    = {SUM_W{1'b0}};
        end else begin
          state_s = EMIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values registered alongside the state they belong to.
  always_comb begin
    busy_s  = (state_s == MAC) || (state_s == SAT) || (state_s == EMIT);
    done_s  = (state_s == DONE);
    valid_s = (state_s == EMIT);
    rd_en_s = 1'b0;
    addr_s  = addr_r;
    if ((state_s == MAC) && (cnt_s < ROW_LAST)) begin
      rd_en_s = 1'b1;
      addr_s  = AW'(int'(neuron_s) * ROW_LEN + int'(cnt_s));
    end else begin
      rd_en_s = 1'b0;
      addr_s  = addr_r;
    end
    if (load_out_s) begin
      id_s   = neuron_r;
      data_s = sat_s;
    end else begin
      id_s   = id_r;
      data_s = data_r;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      neuron_r <= {IDW{1'b0}};
      acc_r    <= {SUM_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      rd_en_r  <= 1'b0;
      valid_r  <= 1'b0;
      addr_r   <= {AW{1'b0}};
      id_r     <= {IDW{1'b0}};
      data_r   <= {INT_WIDTH{1'b0}};
      for (int i = 0; i < N_IN; i++) begin
        in_r[i] <= {INT_WIDTH{1'b0}};
      end
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      neuron_r <= neuron_s;
      acc_r    <= acc_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      rd_en_r  <= rd_en_s;
      valid_r  <= valid_s;
      addr_r   <= addr_s;
      id_r     <= id_s;
      data_r   <= data_s;
      for (int i = 0; i < N_IN; i++) begin
        in_r[i] <= latch_s ? in_vec[i*INT_WIDTH +: INT_WIDTH] : in_r[i];
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign w_rd_en   = rd_en_r;
  assign w_addr    = addr_r;
  assign out_valid = valid_r;
  assign out_id    = id_r;
  assign out_data  = data_r;

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Randomised self-checking bench for neuron_layer_scheduler against an arithmetic layer model.
// Bias checks are compiled in when NEURON_SCHED_BIAS_EN is defined.
module tb_neuron_layer_scheduler;

  localparam int IW = 4;
  localparam int NI = 2;
  localparam int NN = 2;
  localparam int OW = 2;
  localparam int WW = IW + OW + 1;
`ifdef NEURON_SCHED_BIAS_EN
  localparam int ROW = NI + 1;
`else
  localparam int ROW = NI;
`endif
  localparam int NW = NN * ROW;
  localparam int AW = $clog2(NW);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [NI*IW-1:0]     in_vec = '0;
  logic                 busy, done, w_rd_en, out_valid;
  logic                 out_ready = 1'b0;
  logic [AW-1:0]        w_addr;
  logic signed [WW-1:0] w_data = '0;
  logic [0:0]           out_id;
  logic [IW-1:0]        out_data;

  logic signed [WW-1:0] wmem [NW];
  int addr_q[$];
  int got_id[$];
  int got_data[$];
  int first_lat, stall_err, done_cnt, busy_first, busy_after, timed_out;
  int n_vec = 0;
  int n_err = 0;

  neuron_layer_scheduler #(
    .INT_WIDTH(IW), .N_IN(NI), .N_NEURONS(NN), .OVERFLOW_WIDTH(OW), .WEIGHT_WIDTH(WW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Sync-read weight memory and read-address log.
  always @(posedge clk) begin
    if (w_rd_en) begin
      w_data <= wmem[w_addr];
      addr_q.push_back(int'(w_addr));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Layer reference: fixed-point dot product, wrapped to the 11-bit accumulator, then clamped.
  function automatic int model_out(input int n, input logic [NI*IW-1:0] inv);
    int s;
    s = 0;
    for (int k = 0; k < NI; k++) s += int'(inv[k*IW +: IW]) * int'(wmem[n*ROW+k]);
`ifdef NEURON_SCHED_BIAS_EN
    s += int'(wmem[n*ROW+NI]) * 16;
`endif
    s = (((s + 1024) % 2048) + 2048) % 2048 - 1024;
    if (s < 0) return 0;
    if (s >= 256) return 15;
    return s / 16;
  endfunction

  // Drives one layer and records every transfer; mode 0 ready, 1 random ready, 2 five-cycle stall per output.
  task automatic run_layer(input logic [NI*IW-1:0] inv, input int mode, input bit spurious);
    int cyc, stall_left, done_cyc;
    bit hold, fin;
    int hid, hdat;
    got_id.delete(); got_data.delete(); addr_q.delete();
    first_lat = -1; stall_err = 0; done_cnt = 0; timed_out = 0; busy_after = 1;
    hold = 0; fin = 0; stall_left = 5; done_cyc = -1; hid = 0; hdat = 0;
    @(negedge clk);
    in_vec = inv; start = 1'b1; out_ready = (mode == 0);
    cyc = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      in_vec = NI*IW'($urandom);
      if (cyc == 1) busy_first = busy;
      if (spurious && cyc == 2) start = 1'b1;
      if (out_valid && w_rd_en) stall_err++;
      if (out_valid && first_lat < 0) first_lat = cyc;
      if (hold && (!out_valid || int'(out_id) != hid || int'(out_data) != hdat)) stall_err++;
      if (out_valid) begin
        if (mode == 0) out_ready = 1'b1;
        else if (mode == 1) out_ready = 1'($urandom % 2);
        else if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
        else out_ready = 1'b1;
        if (out_ready) begin
          got_id.push_back(int'(out_id)); got_data.push_back(int'(out_data));
          hold = 0; stall_left = 5;
        end else begin
          hold = 1; hid = int'(out_id); hdat = int'(out_data);
        end
      end else begin
        out_ready = (mode == 1) ? 1'($urandom % 2) : (mode == 0);
        hold = 0;
      end
      if (done) done_cnt++;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin busy_after = busy; fin = 1; end
      if (cyc > 400) begin timed_out = 1; fin = 1; end
    end
    out_ready = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy got %b want 0", tag, busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL %s done got %b want 0", tag, done); end
    n_vec++; if (w_rd_en !== 1'b0) begin n_err++; $display("FAIL %s w_rd_en got %b want 0", tag, w_rd_en); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s out_valid got %b want 0", tag, out_valid); end
    n_vec++; if (w_addr !== '0) begin n_err++; $display("FAIL %s w_addr got %0d want 0", tag, w_addr); end
    n_vec++; if (out_id !== '0) begin n_err++; $display("FAIL %s out_id got %0d want 0", tag, out_id); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL %s out_data got %0d want 0", tag, out_data); end
  endtask

  task automatic check_layer(input string tag, input logic [NI*IW-1:0] inv);
    n_vec++; if (timed_out != 0) begin n_err++; $display("FAIL %s timeout got %0d want 0", tag, timed_out); end
    n_vec++; if (got_data.size() != NN) begin n_err++; $display("FAIL %s out_count got %0d want %0d", tag, got_data.size(), NN); end
    for (int n = 0; n < NN; n++) begin
      n_vec++;
      if (n >= got_id.size() || got_id[n] != n)
        begin n_err++; $display("FAIL %s out_id[%0d] got %0d want %0d", tag, n, (n < got_id.size()) ? got_id[n] : -1, n); end
      n_vec++;
      if (n >= got_data.size() || got_data[n] != model_out(n, inv))
        begin n_err++; $display("FAIL %s out_data[%0d] got %0d want %0d", tag, n, (n < got_data.size()) ? got_data[n] : -1, model_out(n, inv)); end
    end
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL %s done_pulses got %0d want 1", tag, done_cnt); end
    n_vec++; if (busy_after != 0) begin n_err++; $display("FAIL %s busy_after_done got %0d want 0", tag, busy_after); end
    n_vec++; if (stall_err != 0) begin n_err++; $display("FAIL %s stall_hold_errors got %0d want 0", tag, stall_err); end
    n_vec++; if (addr_q.size() != NW) begin n_err++; $display("FAIL %s weight_reads got %0d want %0d", tag, addr_q.size(), NW); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_released");
  endtask

  task automatic test_directed();
    logic [NI*IW-1:0] inv;
    for (int i = 0; i < NW; i++) wmem[i] = 7'sd16;
`ifdef NEURON_SCHED_BIAS_EN
    for (int n = 0; n < NN; n++) wmem[n*ROW+NI] = 7'sd0;
`endif
    inv = {4'd4, 4'd4};
    run_layer(inv, 0, 1'b0);
    check_layer("half", inv);
    for (int n = 0; n < NN; n++) begin
      n_vec++; if (n >= got_data.size() || got_data[n] != 8) begin n_err++; $display("FAIL half_value[%0d] want 8", n); end
    end
    n_vec++; if (first_lat != 5) begin n_err++; $display("FAIL first_latency got %0d want 5", first_lat); end
    n_vec++; if (busy_first != 1) begin n_err++; $display("FAIL busy_after_start got %0d want 1", busy_first); end
    for (int i = 0; i < NW; i++) begin
      n_vec++;
      if (i >= addr_q.size() || addr_q[i] != i) begin n_err++; $display("FAIL addr_seq[%0d] got %0d want %0d", i, (i < addr_q.size()) ? addr_q[i] : -1, i); end
    end
    inv = {4'd15, 4'd15};
    run_layer(inv, 0, 1'b0);
    check_layer("overflow", inv);
    for (int n = 0; n < NN; n++) begin
      n_vec++; if (n >= got_data.size() || got_data[n] != 15) begin n_err++; $display("FAIL overflow_value[%0d] want 15", n); end
    end
    for (int n = 0; n < NN; n++) begin wmem[n*ROW] = -7'sd16; wmem[n*ROW+1] = 7'sd8; end
    inv = {4'd4, 4'd8};
    run_layer(inv, 0, 1'b0);
    check_layer("negative", inv);
    for (int n = 0; n < NN; n++) begin
      n_vec++; if (n >= got_data.size() || got_data[n] != 0) begin n_err++; $display("FAIL negative_value[%0d] want 0", n); end
    end
  endtask

  task automatic test_backpressure();
    logic [NI*IW-1:0] inv;
    for (int i = 0; i < NW; i++) wmem[i] = WW'($urandom);
    inv = NI*IW'($urandom);
    run_layer(inv, 2, 1'b0);
    check_layer("backpressure", inv);
  endtask

  task automatic test_random_layers();
    logic [NI*IW-1:0] inv;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NW; i++) wmem[i] = WW'($urandom);
      inv = NI*IW'($urandom);
      run_layer(inv, 1, 1'(t % 2));
      check_layer("random", inv);
    end
  endtask

  task automatic test_reset_mid();
    logic [NI*IW-1:0] inv;
    int waited, bad;
    for (int i = 0; i < NW; i++) wmem[i] = WW'($urandom);
    inv = NI*IW'($urandom);
    @(negedge clk);
    in_vec = inv; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!(w_rd_en && int'(w_addr) == ROW) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_vec++; if (waited >= 100) begin n_err++; $display("FAIL reset_mid_reach_neuron1 got timeout want neuron1 read"); end
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || out_valid || busy) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL reset_mid_quiet got %0d active cycles want 0", bad); end
    run_layer(inv, 0, 1'b0);
    check_layer("after_reset", inv);
  endtask

`ifdef NEURON_SCHED_BIAS_EN
  task automatic test_bias();
    logic [NI*IW-1:0] inv;
    for (int n = 0; n < NN; n++) begin
      for (int k = 0; k < NI; k++) wmem[n*ROW+k] = 7'sd0;
      wmem[n*ROW+NI] = 7'sd8;
    end
    inv = NI*IW'($urandom);
    run_layer(inv, 0, 1'b0);
    check_layer("bias", inv);
    for (int n = 0; n < NN; n++) begin
      n_vec++; if (n >= got_data.size() || got_data[n] != 8) begin n_err++; $display("FAIL bias_value[%0d] want 8", n); end
    end
    for (int i = 0; i < NW; i++) begin
      n_vec++;
      if (i >= addr_q.size() || addr_q[i] != i) begin n_err++; $display("FAIL bias_addr_seq[%0d] want %0d", i, i); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NW; i++) wmem[i] = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_random_layers();
    test_reset_mid();
`ifdef NEURON_SCHED_BIAS_EN
    test_bias();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
